arc4_sched: RTL and testbench
=============================

Name: arc4_sched

Overview:
- Sequencer and S-memory arbiter for the ARC4 core.
- On one top-level en pulse, runs the three phases in order: init (S[i]=i), ksa (key schedule), prga (keystream/decrypt).
- Owns the single-port s_mem: routes exactly one phase's addr/wrdata/wren to the memory at a time.
- Presents the same rdy/en handshake upward that each phase presents to it.

Parameters:
- TIMEOUT_CYCLES, 65535: max cycles a phase may stay busy before error; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  start request; sampled only when rdy=1.
- rdy  out  1  high when idle and able to accept en.
- phase  out  2  current owner: 0 none, 1 init, 2 ksa, 3 prga.
- err  out  1  sticky phase-timeout flag.
- en_init, en_ksa, en_prga  out  1 each  one-cycle start pulses to the phases.
- rdy_init, rdy_ksa, rdy_prga  in  1 each  phase ready/done.
- addr_init, addr_ksa, addr_prga  in  8 each  phase S addresses.
- wrdata_init, wrdata_ksa, wrdata_prga  in  8 each  phase S write data.
- wren_init, wren_ksa, wren_prga  in  1 each  phase S write enables.
- s_addr  out  8  to s_mem address.
- s_wrdata  out  8  to s_mem data.
- s_wren  out  1  to s_mem write enable.

Behaviour:
- Reset (async, rst_n=0): state IDLE, rdy=1, phase=0, err=0, all en_* =0. s_* outputs are forced to 0 as a consequence of phase=0.
- States: IDLE, ARM, GUARD, WAIT, ERR. A 2-bit phase register selects which phase's en/rdy the FSM drives and watches.
- IDLE: rdy=1. On en=1, go to ARM at the next edge with phase=1 and rdy=0. en is ignored whenever rdy=0.
- ARM: hold while the selected rdy_x=0. When rdy_x=1, assert en_x for exactly one cycle (registered) and go to GUARD.
- GUARD: one cycle with en_x=0. rdy_x is ignored, covering phases that drop rdy one cycle late. Then go to WAIT.
- WAIT: on selected rdy_x=1:
  - phase 1 or 2: increment phase and go to ARM.
  - phase 3: set phase=0 and go to IDLE; rdy=1 on the following cycle.
- Minimum overhead per phase is 3 cycles beyond the phase's own busy time (ARM, GUARD, WAIT sample).
- Arbitration is combinational from the phase register:
  - phase 1 selects init inputs; phase 2 ksa; phase 3 prga.
  - phase 0 gives s_addr=0, s_wrdata=0, s_wren=0.
  - A non-owner's wren never reaches memory.
- Ownership changes only in the cycle after the previous owner's rdy is sampled high, so no write is in flight at handover. Any wren_x from a non-owner is dropped.
- No rdy re-assertion mid-sequence: upstream cannot restart until prga completes.
- Reset mid-operation: immediate return to reset values. Phases share rst_n; no partial-state recovery.
- Simultaneous events:
  - en asserted in the same cycle rdy rises is not accepted; acceptance requires rdy=1 at the sampling edge.
  - rdy_x high in ARM on entry produces en_x in the very next cycle.

Optional Feature:
- Macro ARC4_SCHED_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entering ARM and increments in ARM/GUARD/WAIT.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to ERR and sets err=1, phase=0, s_wren=0, rdy=0.
  - ERR is left only by rst_n.
- Undefined: no counter, err tied 0, ERR unreachable.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> rdy=1, phase=0, s_wren=0, all en_* =0. en held 0 for 10 cycles -> no change.
- Full sequence with behavioural phases (init busy 256 cycles, ksa 768, prga 40):
  - en pulse -> en_init, en_ksa, en_prga each high exactly 1 cycle, in order.
  - phase steps 1->2->3->0.
  - rdy returns 1 at 1064 + 9 overhead cycles after acceptance.
  - s_mem contents match reference ARC4 for key 0x00033C.
- Arbitration isolation: during phase 2, drive wren_init=1, addr_init=0x55 -> s_wren follows wren_ksa only; S[0x55] unchanged.
- Late-ready phase: ksa model drops rdy_ksa 1 cycle after en_ksa -> no premature advance; phase stays 2 until rdy_ksa rises.
- Busy phase at ARM: hold rdy_prga=0 for 20 cycles when entering ARM -> en_prga fires only in the cycle after rdy_prga rises. en pulsed while busy -> ignored.
- Reset mid-ksa and timeout:
  - Assert rst_n at cycle 300 of ksa -> all outputs at reset values the same cycle.
  - With ARC4_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=100, hold rdy_init=0 -> err=1 at cycle 100 of init, phase=0, rdy stays 0.

Source files
------------

// File: rtl/arc4_sched_if.sv
// rtl/arc4_sched_if.sv - phase handshake and S-memory port bundle between arc4_sched and its phases
interface arc4_sched_if;
    logic       en_init,     en_ksa,     en_prga;
    logic       rdy_init,    rdy_ksa,    rdy_prga;
    logic [7:0] addr_init,   addr_ksa,   addr_prga;
    logic [7:0] wrdata_init, wrdata_ksa, wrdata_prga;
    logic       wren_init,   wren_ksa,   wren_prga;
    logic [7:0] s_addr;
    logic [7:0] s_wrdata;
    logic       s_wren;

    modport master (
        output en_init, en_ksa, en_prga,
        input  rdy_init, rdy_ksa, rdy_prga,
        input  addr_init, addr_ksa, addr_prga,
        input  wrdata_init, wrdata_ksa, wrdata_prga,
        input  wren_init, wren_ksa, wren_prga,
        output s_addr, s_wrdata, s_wren
    );

    modport slave (
        input  en_init, en_ksa, en_prga,
        output rdy_init, rdy_ksa, rdy_prga,
        output addr_init, addr_ksa, addr_prga,
        output wrdata_init, wrdata_ksa, wrdata_prga,
        output wren_init, wren_ksa, wren_prga,
        input  s_addr, s_wrdata, s_wren
    );
endinterface

// File: rtl/arc4_sched.sv
// rtl/arc4_sched.sv - ARC4 init/ksa/prga sequencer and S-memory arbiter
// Optional phase timeout enabled by ARC4_SCHED_TIMEOUT_EN.
module arc4_sched #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic         rdy,
    output logic [1:0]   phase,
    output logic         err,
    arc4_sched_if.master bus
);
    typedef enum logic [2:0] {IDLE, ARM, GUARD, WAIT, ERR} state_t;

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic       rdy_q,   rdy_d;
    logic       go_q,    go_d;
    logic       rdy_sel;
    logic       busy;

`ifdef ARC4_SCHED_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign busy = (state_q == ARM) || (state_q == GUARD) || (state_q == WAIT);

    always_comb begin
        case (phase_q)
            2'd1:    rdy_sel = bus.rdy_init;
            2'd2:    rdy_sel = bus.rdy_ksa;
            2'd3:    rdy_sel = bus.rdy_prga;
            default: rdy_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        go_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = ARM;
                    phase_d = 2'd1;
                end
            end
            ARM: begin
                if (rdy_sel) begin
                    go_d    = 1'b1;
                    state_d = GUARD;
                end
            end
            // rdy_x may still be high from before the start pulse; skip it.
            GUARD: state_d = WAIT;
            WAIT: begin
                if (rdy_sel) begin
                    if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                        state_d = IDLE;
                    end else begin
                        phase_d = phase_q + 2'd1;
                        state_d = ARM;
                    end
                end
            end
            ERR:     phase_d = 2'd0;
            default: state_d = IDLE;
        endcase
`ifdef ARC4_SCHED_TIMEOUT_EN
        if (busy && (cnt_q == TIMEOUT_CYCLES - 16'd1)) begin
            state_d = ERR;
            phase_d = 2'd0;
            go_d    = 1'b0;
        end
        if ((state_d == ARM) && (state_q != ARM)) begin
            cnt_d = 16'd0;
        end else if (busy) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
        err_d = err_q | (state_d == ERR);
`endif
        rdy_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= 2'd0;
            rdy_q   <= 1'b1;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            rdy_q   <= rdy_d;
            go_q    <= go_d;
        end
    end

`ifdef ARC4_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign rdy         = rdy_q;
    assign phase       = phase_q;
    assign bus.en_init = go_q & (phase_q == 2'd1);
    assign bus.en_ksa  = go_q & (phase_q == 2'd2);
    assign bus.en_prga = go_q & (phase_q == 2'd3);

    // Only the owning phase reaches memory; phase 0 parks the port at zero.
    always_comb begin
        bus.s_addr   = 8'd0;
        bus.s_wrdata = 8'd0;
        bus.s_wren   = 1'b0;
        case (phase_q)
            2'd1: begin
                bus.s_addr   = bus.addr_init;
                bus.s_wrdata = bus.wrdata_init;
                bus.s_wren   = bus.wren_init;
            end
            2'd2: begin
                bus.s_addr   = bus.addr_ksa;
                bus.s_wrdata = bus.wrdata_ksa;
                bus.s_wren   = bus.wren_ksa;
            end
            2'd3: begin
                bus.s_addr   = bus.addr_prga;
                bus.s_wrdata = bus.wrdata_prga;
                bus.s_wren   = bus.wren_prga;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_arc4_sched.sv
// tb/tb_arc4_sched.sv - directed bench for arc4_sched with behavioural init/ksa/prga phases and S memory
module tb_arc4_sched;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rdy;
    logic [1:0] phase;
    logic       err;

    arc4_sched_if bus ();

`ifdef ARC4_SCHED_TIMEOUT_EN
    localparam logic [15:0] TO = 16'd100;
`else
    localparam logic [15:0] TO = 16'd65535;
`endif

    arc4_sched #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .rdy   (rdy),
        .phase (phase),
        .err   (err),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] kbyte(input logic [7:0] i);
        case (i % 8'd3)
            8'd0:    kbyte = 8'h00;
            8'd1:    kbyte = 8'h03;
            default: kbyte = 8'h3C;
        endcase
    endfunction

    logic [7:0] mem [256];
    always @(posedge clk) if (bus.s_wren) mem[bus.s_addr] <= bus.s_wrdata;

    logic hold_init, hold_prga, inj;

    // init phase: 256 busy cycles writing S[i]=i
    logic [8:0] ib;
    logic [7:0] ic, a_init, d_init;
    logic       r_init, w_init;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ib <= 0; ic <= 0; r_init <= 1; w_init <= 0; a_init <= 0; d_init <= 0;
        end else if (bus.en_init) begin
            ib <= 9'd256; ic <= 0; r_init <= 0; w_init <= 0;
        end else if (ib != 0) begin
            ib <= ib - 1;
            if (ib == 1) r_init <= 1;
            a_init <= ic; d_init <= ic; w_init <= 1; ic <= ic + 1;
        end else begin
            w_init <= 0;
        end
    end
    assign bus.rdy_init    = r_init & ~hold_init;
    assign bus.wren_init   = w_init | inj;
    assign bus.addr_init   = inj ? 8'h55 : a_init;
    assign bus.wrdata_init = inj ? 8'hAA : d_init;

    // ksa phase: 768 busy cycles, 3 per swap (settle, write S[i], write S[j])
    logic [9:0] kb;
    logic [1:0] ks;
    logic [7:0] ki, kj, ksi, k_jn, a_ksa, d_ksa;
    logic       r_ksa, w_ksa;
    assign k_jn = kj + mem[ki] + kbyte(ki);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kb <= 0; ks <= 0; ki <= 0; kj <= 0; ksi <= 0; r_ksa <= 1; w_ksa <= 0; a_ksa <= 0; d_ksa <= 0;
        end else if (bus.en_ksa) begin
            kb <= 10'd768; ks <= 0; ki <= 0; kj <= 0; r_ksa <= 0; w_ksa <= 0;
        end else if (kb != 0) begin
            kb <= kb - 1;
            if (kb == 1) r_ksa <= 1;
            ks <= (ks == 2) ? 2'd0 : ks + 2'd1;
            case (ks)
                2'd1: begin
                    ksi <= mem[ki]; a_ksa <= ki; d_ksa <= mem[k_jn]; w_ksa <= 1; kj <= k_jn;
                end
                2'd2: begin
                    a_ksa <= kj; d_ksa <= ksi; w_ksa <= 1; ki <= ki + 1;
                end
                default: w_ksa <= 0;
            endcase
        end else begin
            w_ksa <= 0;
        end
    end
    assign bus.rdy_ksa    = r_ksa;
    assign bus.wren_ksa   = w_ksa;
    assign bus.addr_ksa   = a_ksa;
    assign bus.wrdata_ksa = d_ksa;

    // prga phase: 40 busy cycles, 13 swaps of 3 cycles then one idle cycle
    logic [5:0] pb;
    logic [1:0] ps;
    logic [7:0] pi, pj, psi, p_i1, p_jn, a_prga, d_prga;
    logic       r_prga, w_prga;
    assign p_i1 = pi + 8'd1;
    assign p_jn = pj + mem[p_i1];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pb <= 0; ps <= 0; pi <= 0; pj <= 0; psi <= 0; r_prga <= 1; w_prga <= 0; a_prga <= 0; d_prga <= 0;
        end else if (bus.en_prga) begin
            pb <= 6'd40; ps <= 0; pi <= 0; pj <= 0; r_prga <= 0; w_prga <= 0;
        end else if (pb != 0) begin
            pb <= pb - 1;
            if (pb == 1) r_prga <= 1;
            ps <= (ps == 2) ? 2'd0 : ps + 2'd1;
            case (ps)
                2'd1: begin
                    psi <= mem[p_i1]; a_prga <= p_i1; d_prga <= mem[p_jn]; w_prga <= 1;
                    pi <= p_i1; pj <= p_jn;
                end
                2'd2: begin
                    a_prga <= pj; d_prga <= psi; w_prga <= 1;
                end
                default: w_prga <= 0;
            endcase
        end else begin
            w_prga <= 0;
        end
    end
    assign bus.rdy_prga    = r_prga & ~hold_prga;
    assign bus.wren_prga   = w_prga;
    assign bus.addr_prga   = a_prga;
    assign bus.wrdata_prga = d_prga;

    logic [7:0] ref_s [256];
    logic [7:0] ri, rj, rt;
    int cyc, n_init, n_ksa, n_prga, c_init, c_ksa, c_prga, c2, c3, nbad;
    logic [1:0] last_ph;
    logic       done, seen;

    task automatic start();
        en = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 0; hold_init = 0; hold_prga = 0; inj = 0; rst_n = 0;

        for (int i = 0; i < 256; i++) ref_s[i] = 8'(i);
        rj = 0;
        for (int i = 0; i < 256; i++) begin
            rj = rj + ref_s[i] + kbyte(8'(i));
            rt = ref_s[i]; ref_s[i] = ref_s[rj]; ref_s[rj] = rt;
        end
        ri = 0; rj = 0;
        repeat (13) begin
            ri = ri + 1; rj = rj + ref_s[ri];
            rt = ref_s[ri]; ref_s[ri] = ref_s[rj]; ref_s[rj] = rt;
        end

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        #1;
        check("rst_rdy", rdy, 1);
        check("rst_phase", phase, 0);
        check("rst_err", err, 0);
        check("rst_s_wren", bus.s_wren, 0);
        check("rst_en_x", {bus.en_init, bus.en_ksa, bus.en_prga}, 0);
        repeat (10) @(posedge clk);
        #1;
        check("idle_rdy", rdy, 1);
        check("idle_phase", phase, 0);

`ifdef ARC4_SCHED_TIMEOUT_EN
        hold_init = 1;
        start();
        cyc = 0;
        while (!err && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
        check("to_cycle", cyc, 100);
        check("to_err", err, 1);
        check("to_phase", phase, 0);
        check("to_rdy", rdy, 0);
        en = 1;
        repeat (5) @(posedge clk);
        #1 en = 0;
        check("to_sticky_err", err, 1);
        check("to_stuck_rdy", rdy, 0);
        check("to_stuck_phase", phase, 0);
        rst_n = 0;
        #1;
        check("to_rst_err", err, 0);
        check("to_rst_rdy", rdy, 1);
        @(posedge clk);
        #1 rst_n = 1; hold_init = 0;
`else
        // full sequence with arbitration injection during ksa
        start();
        check("acc_phase", phase, 1);
        check("acc_rdy", rdy, 0);
        cyc = 0; done = 0; last_ph = phase;
        n_init = 0; n_ksa = 0; n_prga = 0; c_init = -1; c_ksa = -1; c_prga = -1; c2 = -1; c3 = -1;
        while (!done && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
            if (bus.en_init) begin n_init++; c_init = cyc; end
            if (bus.en_ksa)  begin n_ksa++;  c_ksa  = cyc; end
            if (bus.en_prga) begin n_prga++; c_prga = cyc; end
            if (phase != last_ph) begin
                if (phase == 2'd2) c2 = cyc;
                if (phase == 2'd3) c3 = cyc;
                check("phase_step", phase, (last_ph == 2'd3) ? 2'd0 : last_ph + 2'd1);
                last_ph = phase;
            end
            if (inj) begin
                check("arb_wren", bus.s_wren, bus.wren_ksa);
                check("arb_addr", bus.s_addr, bus.addr_ksa);
            end
            inj = (cyc >= 400 && cyc < 420);
            done = rdy;
        end
        inj = 0;
        check("seq_rdy_cycle", cyc, 1073);
        check("seq_phase_end", phase, 0);
        check("en_init_cnt", n_init, 1);
        check("en_ksa_cnt", n_ksa, 1);
        check("en_prga_cnt", n_prga, 1);
        check("en_init_cyc", c_init, 1);
        check("en_ksa_cyc", c_ksa, 260);
        check("en_prga_cyc", c_prga, 1031);
        check("phase2_cyc", c2, 259);
        check("ksa_no_early", c3 - c_ksa, 770);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_s[i]) nbad++;
        check("s_mem_bad", nbad, 0);
        check("s_mem_55", mem[8'h55], ref_s[8'h55]);
        check("seq_err", err, 0);

        // prga busy at ARM; en while busy is ignored
        hold_prga = 1;
        start();
        cyc = 0;
        while (phase != 2'd3 && cyc < 2000) begin
            @(posedge clk); #1; cyc++;
        end
        check("busy_reach_p3", phase, 3);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (bus.en_prga) seen = 1;
            en = (k == 10);
        end
        en = 0;
        check("busy_no_en_prga", seen, 0);
        check("busy_phase", phase, 3);
        check("busy_rdy", rdy, 0);
        hold_prga = 0;
        @(posedge clk); #1;
        check("busy_en_prga", bus.en_prga, 1);
        cyc = 0;
        while (!rdy && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) check("busy_en_prga_pulse", bus.en_prga, 0);
        end
        check("busy_rdy_cycle", cyc, 42);
        repeat (3) @(posedge clk);
        #1;
        check("busy_en_ignored", phase, 0);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_s[i]) nbad++;
        check("s_mem_bad_2", nbad, 0);

        // reset in the middle of ksa
        start();
        cyc = 0;
        while (phase != 2'd2 && cyc < 1000) begin
            @(posedge clk); #1; cyc++;
        end
        check("mid_reach_p2", phase, 2);
        repeat (300) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("mid_rst_rdy", rdy, 1);
        check("mid_rst_phase", phase, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_en_x", {bus.en_init, bus.en_ksa, bus.en_prga}, 0);
        check("mid_rst_s_wren", bus.s_wren, 0);
        check("mid_rst_s_addr", bus.s_addr, 0);
        @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_after_rdy", rdy, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
